pulse_stretch: RTL and testbench
================================

PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 Parameter WIDTH, default 8: width of len and of the active-length counter.
REQ-002 Parameter HOLDOFF, default 4: cycles of trigger lockout after each stretched pulse; 0 allowed (no lockout).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 trig  input  1  single-cycle trigger pulse, sampled each rising edge.
REQ-006 len  input  WIDTH  requested out high time in cycles; sampled only when a trigger is accepted.
REQ-007 retrig_en  input  1  1 = a trigger during ACTIVE restarts the count.
REQ-008 out  output  1  stretched level, registered.
REQ-009 busy  output  1  high whenever state is not IDLE, registered.
REQ-010 done  output  1  one-cycle pulse, registered, high in the first cycle out is low after an ACTIVE period.
REQ-011 drop  output  1  combinational, high in any cycle where trig=1 and the trigger is not accepted.

Function
REQ-012 The FSM SHALL have three states: IDLE, ACTIVE, HOLD; out = (state==ACTIVE); busy = (state!=IDLE).
REQ-013 IDLE, trig=1, len!=0 (accept): next state ACTIVE, cnt <= len-1.
REQ-014 IDLE, trig=1, len==0: no state change; drop=1 that cycle.
REQ-015 Trigger accepted at edge k SHALL hold out high for exactly len cycles, starting the cycle after edge k.
REQ-016 ACTIVE, trig=1, retrig_en=1, len!=0: cnt <= len-1 and state stays ACTIVE, so out stays high len more cycles, no gap; counts as accepted (drop=0).
REQ-017 ACTIVE, trig=1, retrig_en=0 or len==0: trigger ignored; drop=1.
REQ-018 ACTIVE, no accepted retrigger, cnt!=0: cnt <= cnt-1.
REQ-019 ACTIVE, no accepted retrigger, cnt==0: next state HOLD with hcnt <= HOLDOFF-1 if HOLDOFF>0, else IDLE; done <= 1 on that edge.
REQ-020 A retrigger in the final ACTIVE cycle (cnt==0) SHALL take priority over expiry: no done, no HOLD.
REQ-021 HOLD: all triggers ignored, drop=1 for each; hcnt decrements; hcnt==0 -> IDLE.
REQ-022 HOLD lasts exactly HOLDOFF cycles; a trig in the first IDLE cycle after HOLD is accepted.
REQ-023 With HOLDOFF=0, a trig in the first cycle out is low (done=1) SHALL be accepted.
REQ-024 done SHALL be low in all cycles except the one following ACTIVE expiry.
REQ-025 len=all-ones SHALL yield 2^WIDTH-1 high cycles; counter SHALL never wrap.
REQ-026 drop SHALL depend only on trig, state, len, retrig_en in the current cycle.

Reset
REQ-027 reset=1 at an edge: state IDLE, cnt=0, hcnt=0; out=0, busy=0, done=0 from the next cycle.
REQ-028 reset SHALL override all other inputs, including trig in the same cycle; reset mid-ACTIVE or mid-HOLD drops out/busy next cycle with no done pulse.
REQ-029 drop SHALL be 0 in any cycle with reset=1.

Verification
REQ-030 Basic: reset 2 cycles, trig 1 cycle with len=3 -> out high exactly 3 cycles, then done=1 for 1 cycle, busy high 3+4=7 cycles, then IDLE.
REQ-031 Retrigger: len=5, retrig_en=1, second trig 3 cycles after first -> out high continuously 3+5=8 cycles, single done.
REQ-032 No retrigger: same stimulus with retrig_en=0 -> out high 5 cycles, drop=1 in the second trig cycle; triggers during the 4 HOLD cycles each give drop=1, out stays 0.
REQ-033 Zero length: len=0, trig in IDLE -> drop=1, busy stays 0, out stays 0, no done.
REQ-034 Reset mid-pulse: len=10, reset asserted 4 cycles into ACTIVE -> out=0 next cycle, done never asserted, next trig after reset released accepted normally.
REQ-035 Boundaries: HOLDOFF=0 build, len=1, trig on done cycle -> out high 1, low 1, high 1; WIDTH=8, len=255 -> exactly 255 high cycles.

Source files
------------

// File: rtl/pulse_stretch.sv
// Pulse stretcher: an accepted trig raises out for len cycles, then a HOLDOFF-cycle lockout.
// out/busy/done are registered (out rises the cycle after the trigger edge); drop is combinational.
module pulse_stretch #(
  parameter int WIDTH   = 8,
  parameter int HOLDOFF = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig,
  input  logic [WIDTH-1:0] len,
  input  logic             retrig_en,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic             drop
);

  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HW-1:0] HLOAD = (HOLDOFF > 0) ? HW'(HOLDOFF - 1) : '0;

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] cnt, cnt_nx;
  logic [HW-1:0]    hcnt, hcnt_nx;
  logic             done_nx;
  logic             accept;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    hcnt_nx  = hcnt;
    done_nx  = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (trig && len != '0) begin
          accept   = 1'b1;
          state_nx = ACTIVE;
          cnt_nx   = len - WIDTH'(1);
        end
      end
      ACTIVE: begin
        // A retrigger beats expiry, even in the last active cycle.
        if (trig && retrig_en && len != '0) begin
          accept = 1'b1;
          cnt_nx = len - WIDTH'(1);
        end else if (cnt != '0) begin
          cnt_nx = cnt - WIDTH'(1);
        end else begin
          done_nx = 1'b1;
          if (HOLDOFF > 0) begin
            state_nx = HOLD;
            hcnt_nx  = HLOAD;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      HOLD: begin
        if (hcnt != '0) hcnt_nx = hcnt - HW'(1);
        else            state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    drop = trig && !accept && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hcnt  <= '0;
      out   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      hcnt  <= hcnt_nx;
      out   <= (state_nx == ACTIVE);
      busy  <= (state_nx != IDLE);
      done  <= done_nx;
    end
  end

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch: a HOLDOFF=4 and a HOLDOFF=0 instance share stimulus and are checked against a timeline model.
module tb_pulse_stretch;

  logic       clk = 1'b0;
  logic       reset, trig, retrig_en;
  logic [7:0] len;
  logic       out_a, busy_a, done_a, drop_a;
  logic       out_b, busy_b, done_b, drop_b;

  always #5 clk = ~clk;

  pulse_stretch #(.WIDTH(8), .HOLDOFF(4)) dut_a (
    .clk(clk), .reset(reset), .trig(trig), .len(len), .retrig_en(retrig_en),
    .out(out_a), .busy(busy_a), .done(done_a), .drop(drop_a)
  );

  pulse_stretch #(.WIDTH(8), .HOLDOFF(0)) dut_b (
    .clk(clk), .reset(reset), .trig(trig), .len(len), .retrig_en(retrig_en),
    .out(out_b), .busy(busy_b), .done(done_b), .drop(drop_b)
  );

  int errors = 0;
  int checks = 0;
  longint cyc = 0;

  // Model: each instance is described by the last cycle out is high, the last busy
  // cycle, and the cycle its done pulse is due, all in absolute cycle numbers.
  longint holdoff [2] = '{4, 0};
  longint out_last [2] = '{-1000, -1000};
  longint hold_last [2] = '{-1000, -1000};
  longint done_at [2] = '{-1000, -1000};

  logic s_out [2], s_busy [2], s_done [2], s_drop [2];
  int cnt_out [2], cnt_done [2], cnt_drop_a;

  task automatic check(input string name, input int d, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d got=%b expected=%b", name, d, cyc, act, exp);
    end
  endtask

  task automatic clear_counts();
    cnt_out  = '{0, 0};
    cnt_done = '{0, 0};
    cnt_drop_a = 0;
  endtask

  task automatic step(input logic r, input logic t, input logic [7:0] l, input logic re);
    logic active, busy_e, done_e, acc;
    reset = r; trig = t; len = l; retrig_en = re;
    #1;
    s_out[0] = out_a; s_busy[0] = busy_a; s_done[0] = done_a; s_drop[0] = drop_a;
    s_out[1] = out_b; s_busy[1] = busy_b; s_done[1] = done_b; s_drop[1] = drop_b;
    for (int i = 0; i < 2; i++) begin
      active = (cyc <= out_last[i]);
      busy_e = (cyc <= hold_last[i]);
      done_e = (cyc == done_at[i]);
      acc    = !r && t && (l != 0) && (!busy_e || (active && re));
      check("out",  i, s_out[i],  active);
      check("busy", i, s_busy[i], busy_e);
      check("done", i, s_done[i], done_e);
      check("drop", i, s_drop[i], !r && t && !acc);
      if (r) begin
        out_last[i] = -1000; hold_last[i] = -1000; done_at[i] = -1000;
      end else if (acc) begin
        out_last[i]  = cyc + longint'(l);
        hold_last[i] = out_last[i] + holdoff[i];
        done_at[i]   = out_last[i] + 1;
      end
      if (s_out[i] === 1'b1)  cnt_out[i]++;
      if (s_done[i] === 1'b1) cnt_done[i]++;
    end
    if (s_drop[0] === 1'b1) cnt_drop_a++;
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic reset2();
    step(1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b0, 8'd0, 1'b0);
  endtask

  // Basic pulse, zero-length trigger and reset-overrides-trigger on the HOLDOFF=4 instance.
  typedef struct {
    logic       r, t, re;
    logic [7:0] l;
    logic       e_out, e_busy, e_done, e_drop;
  } vec_t;

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{r:1, t:0, re:0, l:0, e_out:0, e_busy:0, e_done:0, e_drop:0};
    tbl[1]  = '{r:0, t:1, re:0, l:3, e_out:0, e_busy:0, e_done:0, e_drop:0};
    tbl[2]  = '{r:0, t:0, re:0, l:0, e_out:1, e_busy:1, e_done:0, e_drop:0};
    tbl[3]  = '{r:0, t:0, re:0, l:0, e_out:1, e_busy:1, e_done:0, e_drop:0};
    tbl[4]  = '{r:0, t:0, re:0, l:0, e_out:1, e_busy:1, e_done:0, e_drop:0};
    tbl[5]  = '{r:0, t:0, re:0, l:0, e_out:0, e_busy:1, e_done:1, e_drop:0};
    tbl[6]  = '{r:0, t:0, re:0, l:0, e_out:0, e_busy:1, e_done:0, e_drop:0};
    tbl[7]  = '{r:0, t:0, re:0, l:0, e_out:0, e_busy:1, e_done:0, e_drop:0};
    tbl[8]  = '{r:0, t:0, re:0, l:0, e_out:0, e_busy:1, e_done:0, e_drop:0};
    tbl[9]  = '{r:0, t:0, re:0, l:0, e_out:0, e_busy:0, e_done:0, e_drop:0};
    tbl[10] = '{r:0, t:1, re:1, l:0, e_out:0, e_busy:0, e_done:0, e_drop:1};
    tbl[11] = '{r:0, t:0, re:0, l:0, e_out:0, e_busy:0, e_done:0, e_drop:0};
    tbl[12] = '{r:1, t:1, re:0, l:5, e_out:0, e_busy:0, e_done:0, e_drop:0};
    tbl[13] = '{r:0, t:0, re:0, l:0, e_out:0, e_busy:0, e_done:0, e_drop:0};

    reset = 1'b1; trig = 1'b0; len = 8'd0; retrig_en = 1'b0;
    @(posedge clk); @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].r, tbl[i].t, tbl[i].l, tbl[i].re);
      check("tbl_out",  0, s_out[0],  tbl[i].e_out);
      check("tbl_busy", 0, s_busy[0], tbl[i].e_busy);
      check("tbl_done", 0, s_done[0], tbl[i].e_done);
      check("tbl_drop", 0, s_drop[0], tbl[i].e_drop);
    end

    // Retrigger three cycles after the first: one continuous 8-cycle pulse, one done.
    reset2(); clear_counts();
    step(1'b0, 1'b1, 8'd5, 1'b1);
    idle(2);
    step(1'b0, 1'b1, 8'd5, 1'b1);
    idle(14);
    check("retrig_high_cycles", 0, cnt_out[0] == 8, 1'b1);
    check("retrig_done_count",  0, cnt_done[0] == 1, 1'b1);

    // Same without retrigger; further triggers land in HOLD and are all dropped.
    reset2(); clear_counts();
    step(1'b0, 1'b1, 8'd5, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 8'd5, 1'b0);
    idle(2);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 8'd2, 1'b0);
    check("noretrig_hold_out", 0, s_out[0], 1'b0);
    idle(3);
    check("noretrig_high_cycles", 0, cnt_out[0] == 5, 1'b1);
    check("noretrig_drop_count",  0, cnt_drop_a == 5, 1'b1);

    // Reset four cycles into a 10-cycle pulse: no done, next trigger accepted.
    reset2(); clear_counts();
    step(1'b0, 1'b1, 8'd10, 1'b0);
    idle(4);
    step(1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b0, 8'd0, 1'b0);
    check("rst_mid_out_low", 0, s_out[0], 1'b0);
    idle(12);
    check("rst_mid_no_done", 0, cnt_done[0] == 0, 1'b1);
    step(1'b0, 1'b1, 8'd3, 1'b0);
    step(1'b0, 1'b0, 8'd0, 1'b0);
    check("rst_mid_retrig_ok", 0, s_out[0], 1'b1);
    idle(8);

    // HOLDOFF=0: len=1, trigger again on the done cycle -> high, low, high.
    reset2();
    step(1'b0, 1'b1, 8'd1, 1'b0);
    step(1'b0, 1'b0, 8'd0, 1'b0);
    check("h0_first_high", 1, s_out[1], 1'b1);
    step(1'b0, 1'b1, 8'd1, 1'b0);
    check("h0_gap_low", 1, s_out[1], 1'b0);
    check("h0_gap_done", 1, s_done[1], 1'b1);
    step(1'b0, 1'b0, 8'd0, 1'b0);
    check("h0_second_high", 1, s_out[1], 1'b1);
    idle(6);

    // Maximum length: exactly 255 high cycles, no wrap.
    reset2(); clear_counts();
    step(1'b0, 1'b1, 8'd255, 1'b0);
    idle(270);
    check("len255_high_cycles", 0, cnt_out[0] == 255, 1'b1);
    check("len255_high_cycles", 1, cnt_out[1] == 255, 1'b1);

    // Random traffic against the model.
    reset2();
    for (int k = 0; k < 3000; k++) begin
      logic       r, t, re;
      logic [7:0] l;
      r  = ($urandom_range(0, 99) == 0);
      t  = ($urandom_range(0, 2) == 0);
      l  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
      re = 1'($urandom_range(0, 1));
      step(r, t, l, re);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
